securitybox_ctrl_param: RTL

Parametrised next-generation security-box controller. Accepts a keypad code of CODE_LEN digits, each KEY_W bits wide, and pulses the door-release solenoid when the code matches. It escalates to a long lockout after MAX_FAILS consecutive wrong codes and re-locks if the door is not opened within OPEN_TIMEOUT cycles. Sits between the debounced keypad/door-switch inputs and the solenoid/LED drivers on the board top level.

---
 rtl/securitybox_pkg.sv | 44 ++++
 rtl/secbox_timer.sv | 35 +++
 rtl/securitybox_ctrl_param.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/securitybox_pkg.sv
// Shared types, default timings and code-digit helper for the security-box controller.
// Optional code programming is enabled by SECBOX_PROG_CODE_EN.
package securitybox_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        UNLOCK,
        OPENWAIT,
        DOOROPEN,
        WRONG,
        LOCKOUT,
        PROG
    } secbox_state_t;

    localparam int          DEF_KEY_W            = 4;
    localparam int          DEF_CODE_LEN         = 4;
    localparam logic [15:0] DEF_DEFAULT_CODE     = 16'h9520;
    localparam int          DEF_LOCK_CYCLES      = 10;
    localparam int          DEF_LONG_LOCK_CYCLES = 40;
    localparam int          DEF_MAX_FAILS        = 3;
    localparam int          DEF_OPEN_TIMEOUT     = 50;

    localparam int MAX_CODE_W = 256;

    // Digit idx of a code; digit 0 is the most significant field.
    function automatic logic [MAX_CODE_W-1:0] digit_of(
        input logic [MAX_CODE_W-1:0] code,
        input int                    idx,
        input int                    key_w,
        input int                    code_len
    );
        logic [MAX_CODE_W-1:0] mask;
        mask = (MAX_CODE_W'(1) << key_w) - MAX_CODE_W'(1);
        return (code >> ((code_len - 1 - idx) * key_w)) & mask;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/secbox_timer.sv
// Clearable, enabled up-counter with terminal-count compare against a supplied limit.
module secbox_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == limit);

endmodule

// File: rtl/securitybox_ctrl_param.sv
// Keypad security-box controller: code entry, unlock/open timeout, wrong-code and lockout timing.
// Define SECBOX_PROG_CODE_EN to add ProgMode and a reprogrammable code register.
module securitybox_ctrl_param
    import securitybox_pkg::*;
#(
    parameter int                         KEY_W            = DEF_KEY_W,
    parameter int                         CODE_LEN         = DEF_CODE_LEN,
    parameter logic [KEY_W*CODE_LEN-1:0]  DEFAULT_CODE     = DEF_DEFAULT_CODE,
    parameter int                         LOCK_CYCLES      = DEF_LOCK_CYCLES,
    parameter int                         LONG_LOCK_CYCLES = DEF_LONG_LOCK_CYCLES,
    parameter int                         MAX_FAILS        = DEF_MAX_FAILS,
    parameter int                         OPEN_TIMEOUT     = DEF_OPEN_TIMEOUT
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [KEY_W-1:0]               Key,
    input  logic                           PressedKey,
    input  logic                           DoorSw,
`ifdef SECBOX_PROG_CODE_EN
    input  logic                           ProgMode,
`endif
    output logic                           OpenDoor,
    output logic                           OpenDoorLed,
    output logic                           ClosedDoorLed,
    output logic                           WrongPWLed,
    output logic                           LockedOut,
    output logic [$clog2(MAX_FAILS+1)-1:0] FailCount
);

    localparam int CODE_W  = KEY_W * CODE_LEN;
    localparam int FC_W    = $clog2(MAX_FAILS + 1);
    localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int TMR_MAX = max3(LOCK_CYCLES, LONG_LOCK_CYCLES, OPEN_TIMEOUT);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAILS);

    secbox_state_t    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic [FC_W-1:0]  fail_q, fail_d;
    logic [FC_W-1:0]  fail_inc;
    logic [IDX_W-1:0] cur_idx;
    logic             press_ok;
    logic             key_ok;
    logic             err_new;
    logic             tmr_clear;
    logic             tmr_en;
    logic [TMR_W-1:0] tmr_limit;
    logic             tmr_tc;
    logic [CODE_W-1:0] code_q;

`ifdef SECBOX_PROG_CODE_EN
    logic [CODE_W-1:0] code_d;
    logic [CODE_W-1:0] shadow_q, shadow_d;
    logic [CODE_W-1:0] shadow_shift;

    // Digits arrive most-significant first, so each new one enters at the LS end.
    if (CODE_LEN > 1) begin : g_shift
        assign shadow_shift = {shadow_q[CODE_W-KEY_W-1:0], Key};
    end else begin : g_shift1
        assign shadow_shift = Key;
    end
`else
    assign code_q = DEFAULT_CODE;
`endif

    assign press_ok = PressedKey && !DoorSw && ((state_q == IDLE) || (state_q == ENTRY));
    assign cur_idx  = (state_q == ENTRY) ? idx_q : '0;
    assign key_ok   = (digit_of(MAX_CODE_W'(code_q), int'(cur_idx), KEY_W, CODE_LEN)
                       == MAX_CODE_W'(Key));
    assign err_new  = ((state_q == ENTRY) ? err_q : 1'b0) | ~key_ok;
    assign fail_inc = (fail_q < FC_MAX) ? fail_q + FC_W'(1) : fail_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        fail_d  = fail_q;
`ifdef SECBOX_PROG_CODE_EN
        code_d   = code_q;
        shadow_d = shadow_q;
`endif
        case (state_q)
            IDLE, ENTRY: begin
                if (press_ok) begin
                    if (cur_idx == LAST_IDX) begin
                        idx_d = '0;
                        err_d = 1'b0;
                        if (!err_new) begin
                            state_d = UNLOCK;
                        end else begin
                            fail_d  = fail_inc;
                            state_d = (fail_inc < FC_MAX) ? WRONG : LOCKOUT;
                        end
                    end else begin
                        idx_d   = cur_idx + IDX_W'(1);
                        err_d   = err_new;
                        state_d = ENTRY;
                    end
                end
            end
            UNLOCK: begin
                fail_d  = '0;
                state_d = OPENWAIT;
            end
            OPENWAIT: begin
                if (DoorSw) begin
                    state_d = DOOROPEN;
                end else if (tmr_tc) begin
                    state_d = IDLE;
                end
            end
            DOOROPEN: begin
`ifdef SECBOX_PROG_CODE_EN
                if (ProgMode) begin
                    idx_d   = '0;
                    state_d = PROG;
                end else if (!DoorSw) begin
                    state_d = IDLE;
                end
`else
                if (!DoorSw) begin
                    state_d = IDLE;
                end
`endif
            end
            WRONG: begin
                if (tmr_tc) begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (tmr_tc) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end
            end
            PROG: begin
`ifdef SECBOX_PROG_CODE_EN
                if (!ProgMode) begin
                    idx_d   = '0;
                    state_d = DOOROPEN;
                end else if (PressedKey) begin
                    shadow_d = shadow_shift;
                    if (idx_q == LAST_IDX) begin
                        code_d  = shadow_shift;
                        idx_d   = '0;
                        state_d = DOOROPEN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tmr_en    = 1'b0;
        tmr_limit = '0;
        case (state_q)
            OPENWAIT: begin
                tmr_en    = 1'b1;
                tmr_limit = TMR_W'(OPEN_TIMEOUT - 1);
            end
            WRONG: begin
                tmr_en    = 1'b1;
                tmr_limit = TMR_W'(LOCK_CYCLES - 1);
            end
            LOCKOUT: begin
                tmr_en    = 1'b1;
                tmr_limit = TMR_W'(LONG_LOCK_CYCLES - 1);
            end
            default: ;
        endcase
    end

    assign tmr_clear = (state_d != state_q);

    secbox_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk   (Clk),
        .reset (Reset),
        .clear (tmr_clear),
        .en    (tmr_en),
        .limit (tmr_limit),
        .tc    (tmr_tc)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            fail_q  <= '0;
`ifdef SECBOX_PROG_CODE_EN
            code_q   <= DEFAULT_CODE;
            shadow_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
`ifdef SECBOX_PROG_CODE_EN
            code_q   <= code_d;
            shadow_q <= shadow_d;
`endif
        end
    end

    always_comb begin
        OpenDoor      = 1'b0;
        OpenDoorLed   = 1'b0;
        ClosedDoorLed = 1'b0;
        WrongPWLed    = 1'b0;
        LockedOut     = 1'b0;
        case (state_q)
            IDLE, ENTRY:        ClosedDoorLed = 1'b1;
            UNLOCK: begin
                OpenDoor    = 1'b1;
                OpenDoorLed = 1'b1;
            end
            OPENWAIT, DOOROPEN: OpenDoorLed   = 1'b1;
            WRONG:              WrongPWLed    = 1'b1;
            LOCKOUT: begin
                WrongPWLed = 1'b1;
                LockedOut  = 1'b1;
            end
            PROG:               OpenDoorLed   = 1'b1;
            default: ;
        endcase
    end

    assign FailCount = fail_q;

endmodule
